speed_ramp_ctrl: RTL and testbench

SPEED_RAMP_CTRL -- requirements
Module: speed_ramp_ctrl

---
 rtl/speed_ramp_pkg.sv | 18 +
 rtl/debounce_sync.sv | 47 ++++
 rtl/speed_ramp_ctrl.sv | 163 ++++++++++++++++
 tb/tb_speed_ramp_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/speed_ramp_pkg.sv
// Shared types and default constants for the speed ramp controller.
package speed_ramp_pkg;

    localparam int SPEED_W = 3;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1024;
    localparam int DEF_STEP_CYCLES     = 4096;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RAMP = 2'b01,
        ST_RUN  = 2'b10,
        ST_STOP = 2'b11
    } state_t;

endpackage

// File: rtl/debounce_sync.sv
// Synchronizer chain followed by a stable-level debouncer for one asynchronous bit.
module debounce_sync
    import speed_ramp_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   synced;
    logic [CNT_W-1:0]       cnt_q;

    assign synced = sync_p0[SYNC_STAGES-1];

    // Metastability chain: the raw input enters at bit 0, the safe copy leaves the top bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
        end
    end

    // Accept a new level only after it has differed from the current one for the full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dout  <= 1'b0;
        end else if (synced == dout) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            dout  <= synced;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/speed_ramp_ctrl.sv
// Enable/speed ramp controller: debounced enable, synchronized target, stepped speed FSM.
module speed_ramp_ctrl
    import speed_ramp_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STEP_CYCLES     = DEF_STEP_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_req,
    input  logic [SPEED_W-1:0] speed_target,
    output logic [SPEED_W-1:0] speed_out,
    output logic               enable_out,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    localparam int TMR_W = $clog2(STEP_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_CYCLES - 1);
    localparam logic signed [1:0] DIR_UP = 2'sb01;
    localparam logic signed [1:0] DIR_DN = 2'sb11;

    state_t                             state_q;
    state_t                             state_nxt;
    logic                               en_deb;
    logic [SYNC_STAGES-1:0][SPEED_W-1:0] tgt_p0;
    logic [SPEED_W-1:0]                 tgt;
    logic [TMR_W-1:0]                   tmr_q;
    logic                               stepping;
    logic                               step_tick;
    logic [SPEED_W-1:0]                 speed_nxt;
    logic                               enable_nxt;
    logic                               busy_nxt;

    // One level move in the given direction, clamped to the legal speed range.
    function automatic logic [SPEED_W-1:0] sat_step(input logic [SPEED_W-1:0] lvl,
                                                    input logic signed [1:0] dir);
        logic signed [SPEED_W+1:0] sum;
        sum = $signed({2'b00, lvl}) + dir;
        if (sum[SPEED_W+1]) begin
            return '0;
        end else if (sum[SPEED_W]) begin
            return SPEED_MAX;
        end
        return sum[SPEED_W-1:0];
    endfunction

    debounce_sync #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_enable_db (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (enable_req),
        .dout  (en_deb)
    );

    assign tgt       = tgt_p0[SYNC_STAGES-1];
    assign stepping  = (state_q == ST_RAMP) || (state_q == ST_STOP);
    assign step_tick = stepping && (tmr_q == TMR_LAST);
    assign state_dbg = state_q;

    // Target is quasi-static, so each bit only needs the synchronizer chain, no debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_p0 <= '0;
        end else begin
            tgt_p0 <= {tgt_p0[SYNC_STAGES-2:0], speed_target};
        end
    end

    // Step timer restarts on every state change and only runs while ramping or stopping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else if ((state_nxt != state_q) || !stepping || step_tick) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode; a dropped enable beats any target change.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (en_deb) state_nxt = ST_RAMP;
            ST_RAMP: begin
                if (!en_deb)               state_nxt = ST_STOP;
                else if (speed_out == tgt) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!en_deb)               state_nxt = ST_STOP;
                else if (speed_out != tgt) state_nxt = ST_RAMP;
            end
            ST_STOP: begin
                if (en_deb)                                  state_nxt = ST_RAMP;
                else if (step_tick && (speed_out <= 3'd1))   state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: next speed, enable and busy values for the output registers.
    always_comb begin
        speed_nxt  = speed_out;
        enable_nxt = enable_out;
        case (state_q)
            ST_IDLE: begin
                speed_nxt  = '0;
                enable_nxt = en_deb;
            end
            ST_RAMP: begin
                enable_nxt = 1'b1;
                if (en_deb && (speed_out != tgt) && step_tick) begin
                    speed_nxt = sat_step(speed_out, (tgt > speed_out) ? DIR_UP : DIR_DN);
                end
            end
            ST_RUN: enable_nxt = 1'b1;
            ST_STOP: begin
                if (en_deb) begin
                    enable_nxt = 1'b1;
                end else if (step_tick) begin
                    if (speed_out > 3'd1) begin
                        speed_nxt = sat_step(speed_out, DIR_DN);
                    end else begin
                        speed_nxt  = '0;
                        enable_nxt = 1'b0;
                    end
                end
            end
            default: begin
                speed_nxt  = '0;
                enable_nxt = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt == ST_RAMP) || (state_nxt == ST_STOP);
    end

    // Output registers feeding the downstream PWM stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_out  <= '0;
            enable_out <= 1'b0;
            busy       <= 1'b0;
        end else begin
            speed_out  <= speed_nxt;
            enable_out <= enable_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// Directed-sequence bench with randomized targets and a timeline reference model.
module tb_speed_ramp_ctrl;

    localparam int SS  = 2;
    localparam int DB  = 4;
    localparam int SC  = 8;
    localparam int LAT = SS + DB + 1;
    localparam int TGT_LAT = SS + 1;
    localparam int S_IDLE = 0, S_RAMP = 1, S_RUN = 2, S_STOP = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable_req;
    logic [2:0] speed_target;
    logic [2:0] speed_out;
    logic       enable_out;
    logic       busy;
    logic [1:0] state_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    speed_ramp_ctrl #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DB),
        .STEP_CYCLES     (SC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_req   (enable_req),
        .speed_target (speed_target),
        .speed_out    (speed_out),
        .enable_out   (enable_out),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int sp, input int en, input int st);
        chk({tag, ".speed"}, 8'(speed_out),  8'(sp));
        chk({tag, ".en"},    8'(enable_out), 8'(en));
        chk({tag, ".state"}, 8'(state_dbg),  8'(st));
        chk({tag, ".busy"},  8'(busy),       8'((st == S_RAMP) || (st == S_STOP)));
    endtask

    // Speed m cycles after RAMP entry: one level per SC cycles toward t, then hold.
    function automatic int ramp_lvl(input int s, input int t, input int m);
        int mag, k;
        mag = (t > s) ? t - s : s - t;
        k = m / SC;
        if (k > mag) k = mag;
        return (t >= s) ? s + k : s - k;
    endfunction

    function automatic int ramp_state(input int s, input int t, input int m);
        int mag;
        mag = (t > s) ? t - s : s - t;
        return (m <= SC * mag) ? S_RAMP : S_RUN;
    endfunction

    // Speed m cycles after STOP entry: drops one level per tick; the s-th tick lands in IDLE.
    function automatic int stop_lvl(input int s, input int m);
        int k;
        k = m / SC;
        return (k < s) ? s - k : 0;
    endfunction

    function automatic int stop_state(input int s, input int m);
        return ((m / SC) < s) ? S_STOP : S_IDLE;
    endfunction

    task automatic ramp_from_idle(input string tag, input int t);
        speed_target = 3'(t);
        enable_req   = 1'b1;
        for (int n = 1; n <= LAT + SC * t + 2; n++) begin
            step_clk();
            if (n < LAT) chk_all($sformatf("%s[%0d]", tag, n), 0, 0, S_IDLE);
            else chk_all($sformatf("%s[%0d]", tag, n), ramp_lvl(0, t, n - LAT), 1,
                         ramp_state(0, t, n - LAT));
        end
    endtask

    initial begin
        int  t1, t2, t3, r, s1, d, tgt4, st, total;
        bit  found;

        rst_n = 1'b1;
        enable_req = 1'b0;
        speed_target = 3'd0;
        #1 rst_n = 1'b0;
        #1 chk_all("reset", 0, 0, S_IDLE);
        step_clk();
        step_clk();
        chk_all("reset_hold", 0, 0, S_IDLE);
        #2 rst_n = 1'b1;

        // Short enable pulse must be rejected.
        enable_req = 1'b1;
        for (int n = 1; n <= 3; n++) step_clk();
        enable_req = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step_clk();
            chk($sformatf("glitch_en[%0d]", n), 8'(enable_out), 8'd0);
            chk($sformatf("glitch_state[%0d]", n), 8'(state_dbg), 8'(S_IDLE));
        end

        // Ramp up from IDLE.
        t1 = $urandom_range(3, 7);
        ramp_from_idle("rampup", t1);

        // Retarget while running.
        do t2 = $urandom_range(1, 7); while (t2 == t1);
        speed_target = 3'(t2);
        d = (t2 > t1) ? t2 - t1 : t1 - t2;
        for (int n = 1; n <= TGT_LAT + SC * d + 2; n++) begin
            step_clk();
            if (n < TGT_LAT) chk_all($sformatf("retgt[%0d]", n), t1, 1, S_RUN);
            else chk_all($sformatf("retgt[%0d]", n), ramp_lvl(t1, t2, n - TGT_LAT), 1,
                         ramp_state(t1, t2, n - TGT_LAT));
        end

        // Stop from RUN down to IDLE.
        enable_req = 1'b0;
        for (int n = 1; n <= LAT + SC * t2 + 3; n++) begin
            step_clk();
            if (n < LAT) begin
                chk_all($sformatf("stop[%0d]", n), t2, 1, S_RUN);
            end else begin
                st = stop_state(t2, n - LAT);
                chk_all($sformatf("stop[%0d]", n), stop_lvl(t2, n - LAT),
                        (st != S_IDLE) ? 1 : 0, st);
            end
        end

        // Resume from STOP keeps the current speed and never drops enable.
        t3 = $urandom_range(3, 7);
        ramp_from_idle("ramp2", t3);
        r  = $urandom_range(8, 15);
        s1 = stop_lvl(t3, r - 1);
        total = r + LAT + SC * (t3 - s1) + 2;
        enable_req = 1'b0;
        for (int n = 1; n <= total; n++) begin
            step_clk();
            if (n < LAT)
                chk_all($sformatf("resume[%0d]", n), t3, 1, S_RUN);
            else if (n < r + LAT)
                chk_all($sformatf("resume[%0d]", n), stop_lvl(t3, n - LAT), 1,
                        stop_state(t3, n - LAT));
            else
                chk_all($sformatf("resume[%0d]", n), ramp_lvl(s1, t3, n - r - LAT), 1,
                        ramp_state(s1, t3, n - r - LAT));
            if (n == r) enable_req = 1'b1;
        end

        // Asynchronous reset while ramping through level 4.
        tgt4 = (t3 >= 4) ? 0 : 7;
        speed_target = 3'(tgt4);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            step_clk();
            if (speed_out == 3'd4 && state_dbg == 2'(S_RAMP)) found = 1'b1;
        end
        chk("reach_ramp4", 8'(found), 8'd1);
        #2 rst_n = 1'b0;
        #1 chk_all("async_reset", 0, 0, S_IDLE);
        #2 rst_n = 1'b1;

        // First enable after reset needs the whole debounce window.
        for (int n = 1; n <= LAT + 1; n++) begin
            step_clk();
            if (n < LAT) chk_all($sformatf("post_rst[%0d]", n), 0, 0, S_IDLE);
            else chk_all($sformatf("post_rst[%0d]", n), ramp_lvl(0, tgt4, n - LAT), 1,
                         ramp_state(0, tgt4, n - LAT));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
